alu4b_seq: RTL and testbench

//  Operand/opcode entry sequencer that drives alu4b from a single 4-bit switch bank and one pushbutton.

---
 rtl/alu4b_seq_pkg.sv | 20 ++
 rtl/alu4b.sv | 37 +++
 rtl/alu4b_seq_debounce_btn.sv | 47 ++++
 rtl/decodificador.sv | 29 ++
 rtl/alu4b_seq.sv | 103 ++++++++++
 tb/tb_alu4b_seq.sv | 203 ++++++++++++++++++++
 6 files changed

// File: rtl/alu4b_seq_pkg.sv
// Shared types and constants for the alu4b entry sequencer.
package alu4b_seq_pkg;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RUN = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  function automatic logic [3:0] step_onehot(input state_t s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/alu4b.sv
// Combinational 4-bit ALU: add, subtract, and, or; result shown on a 7-segment digit.
module alu4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       s1,
  input  logic       s0,
  output logic       cout_som,
  output logic       cout_sub,
  output logic [6:0] seg_out
);

  logic [4:0] w_sum;
  logic [4:0] w_dif;
  logic [3:0] w_res;

  assign w_sum    = {1'b0, a} + {1'b0, b};
  // Subtraction as a + ~b + 1, so cout_sub=1 means no borrow.
  assign w_dif    = {1'b0, a} + {1'b0, ~b} + 5'd1;
  assign cout_som = w_sum[4];
  assign cout_sub = w_dif[4];

  always_comb begin
    w_res = 4'h0;
    case ({s1, s0})
      2'b00:   w_res = w_sum[3:0];
      2'b01:   w_res = w_dif[3:0];
      2'b10:   w_res = a & b;
      default: w_res = a | b;
    endcase
  end

  decodificador u_dec (
    .i_val(w_res),
    .o_seg(seg_out)
  );

endmodule

// File: rtl/alu4b_seq_debounce_btn.sv
// Pushbutton synchronizer and debouncer; emits a one-cycle pulse per accepted press.
module debounce_btn #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= btn;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      // Any return to the stable level restarts the qualification window.
      if (r_sync2 != r_stable) begin
        if (r_cnt == CNT_LAST) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign press = r_stable & ~r_stable_d;

endmodule

// File: rtl/decodificador.sv
// Hex digit to 7-segment decoder, active-high segments, bit order {a..g}.
module decodificador (
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h00;
    case (i_val)
      4'h0: o_seg = 7'h7E;
      4'h1: o_seg = 7'h30;
      4'h2: o_seg = 7'h6D;
      4'h3: o_seg = 7'h79;
      4'h4: o_seg = 7'h33;
      4'h5: o_seg = 7'h5B;
      4'h6: o_seg = 7'h5F;
      4'h7: o_seg = 7'h70;
      4'h8: o_seg = 7'h7F;
      4'h9: o_seg = 7'h7B;
      4'hA: o_seg = 7'h77;
      4'hB: o_seg = 7'h1F;
      4'hC: o_seg = 7'h4E;
      4'hD: o_seg = 7'h3D;
      4'hE: o_seg = 7'h4F;
      default: o_seg = 7'h47;
    endcase
  end

endmodule

// File: rtl/alu4b_seq.sv
// Operand/opcode entry sequencer for alu4b: one switch bank, one enter button, one display digit.
module alu4b_seq
  import alu4b_seq_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       s1,
  output logic       s0,
  input  logic       cout_som,
  input  logic       cout_sub,
  input  logic [6:0] seg_alu,
  output logic [6:0] seg,
  output logic [3:0] step,
  output logic       flag_c
);

  state_t     r_state;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [1:0] r_op;
  logic [3:0] r_step;
  logic       r_flag_c;
  logic       w_press;
  logic [6:0] w_seg_sw;

  debounce_btn #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_db (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .press(w_press)
  );

  decodificador u_dec (
    .i_val(sw),
    .o_seg(w_seg_sw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_A;
      r_a      <= 4'h0;
      r_b      <= 4'h0;
      r_op     <= OP_ADD;
      r_step   <= step_onehot(S_A);
      r_flag_c <= 1'b0;
    end else begin
      if (r_state == S_RUN) begin
        case (r_op)
          OP_ADD:  r_flag_c <= cout_som;
          OP_SUB:  r_flag_c <= cout_sub;
          default: r_flag_c <= 1'b0;
        endcase
      end else begin
        r_flag_c <= 1'b0;
      end

      case (r_state)
        S_A: if (w_press) begin
          r_a     <= sw;
          r_state <= S_B;
          r_step  <= step_onehot(S_B);
        end
        S_B: if (w_press) begin
          r_b     <= sw;
          r_state <= S_OP;
          r_step  <= step_onehot(S_OP);
        end
        S_OP: if (w_press) begin
          r_op    <= sw[1:0];
          r_state <= S_RUN;
          r_step  <= step_onehot(S_RUN);
        end
        S_RUN: if (w_press) begin
          r_state <= S_A;
          r_step  <= step_onehot(S_A);
        end
        default: begin
          r_state <= S_A;
          r_step  <= step_onehot(S_A);
        end
      endcase
    end
  end

  assign seg    = (r_state == S_RUN) ? seg_alu : w_seg_sw;
  assign a      = r_a;
  assign b      = r_b;
  assign s1     = r_op[1];
  assign s0     = r_op[0];
  assign step   = r_step;
  assign flag_c = r_flag_c;

endmodule

// File: tb/tb_alu4b_seq.sv
// Scoreboard bench for alu4b_seq driving a real alu4b, with a short debounce window.
module tb_alu4b_seq;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic       btn;
  logic [3:0] a;
  logic [3:0] b;
  logic       s1;
  logic       s0;
  logic       cout_som;
  logic       cout_sub;
  logic [6:0] seg_alu;
  logic [6:0] seg;
  logic [3:0] step;
  logic       flag_c;

  alu4b_seq #(
    .DB_CYCLES(4),
    .CNT_W    (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw      (sw),
    .btn     (btn),
    .a       (a),
    .b       (b),
    .s1      (s1),
    .s0      (s0),
    .cout_som(cout_som),
    .cout_sub(cout_sub),
    .seg_alu (seg_alu),
    .seg     (seg),
    .step    (step),
    .flag_c  (flag_c)
  );

  alu4b u_alu (
    .a       (a),
    .b       (b),
    .s1      (s1),
    .s0      (s0),
    .cout_som(cout_som),
    .cout_sub(cout_sub),
    .seg_out (seg_alu)
  );

  typedef struct {
    logic [3:0] step;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [3:0] prev_step;
  int         m_state  = 0;
  logic [3:0] m_a      = 4'h0;
  logic [3:0] m_b      = 4'h0;
  logic [1:0] m_op     = 2'b00;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every step change outside reset must match the oldest pending press.
  always @(negedge clk) begin
    if (rst) begin
      prev_step = step;
    end else if (step !== prev_step) begin
      exp_t e;
      prev_step = step;
      if (q.size() == 0) begin
        chk("unexpected_step_change", {28'h0, step}, {28'h0, 4'hF});
      end else begin
        e = q.pop_front();
        chk("step", {28'h0, step}, {28'h0, e.step});
        chk("a", {28'h0, a}, {28'h0, e.a});
        chk("b", {28'h0, b}, {28'h0, e.b});
        chk("op", {30'h0, s1, s0}, {30'h0, e.op});
        chk("press_latency", cyc, e.cyc);
      end
    end
  end

  task automatic press_hold(input logic [3:0] v, input bit bounce);
    exp_t e;
    sw = v;
    if (bounce) begin
      for (int i = 0; i < 10; i++) begin
        btn = (i % 2 == 0);
        repeat (2) @(negedge clk);
      end
    end
    btn = 1'b1;
    case (m_state)
      0: m_a  = v;
      1: m_b  = v;
      2: m_op = v[1:0];
      default: ;
    endcase
    m_state = (m_state + 1) % 4;
    e.step = 4'b0001 << m_state;
    e.a    = m_a;
    e.b    = m_b;
    e.op   = m_op;
    e.cyc  = cyc + 7;
    q.push_back(e);
    repeat (7) @(negedge clk);
  endtask

  task automatic release_btn();
    btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic run_op(input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vop,
                        input logic exp_flag, input logic [6:0] exp_seg, input bit bounce_a);
    press_hold(va, bounce_a);
    release_btn();
    press_hold(vb, 1'b0);
    release_btn();
    press_hold(vop, 1'b0);
    chk("flag_on_entry", {31'h0, flag_c}, 32'h0);
    @(negedge clk);
    chk("flag_run", {31'h0, flag_c}, {31'h0, exp_flag});
    chk("seg_run", {25'h0, seg}, {25'h0, exp_seg});
    release_btn();
    press_hold(4'hC, 1'b0);
    @(negedge clk);
    chk("flag_after_wrap", {31'h0, flag_c}, 32'h0);
    chk("seg_after_wrap", {25'h0, seg}, {25'h0, 7'h4E});
    release_btn();
  endtask

  initial begin
    rst = 1'b0;
    btn = 1'b0;
    sw  = 4'h5;
    #3 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_step", {28'h0, step}, 32'h1);
    chk("rst_a", {28'h0, a}, 32'h0);
    chk("rst_b", {28'h0, b}, 32'h0);
    chk("rst_op", {30'h0, s1, s0}, 32'h0);
    chk("rst_flag", {31'h0, flag_c}, 32'h0);
    chk("rst_seg", {25'h0, seg}, {25'h0, 7'h5B});
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_op(4'h9, 4'h8, 4'b0000, 1'b1, 7'h30, 1'b0);  // 9+8=17: carry, shows 1
    run_op(4'h3, 4'h5, 4'b1101, 1'b0, 7'h4F, 1'b1);  // 3-5 borrows, shows E
    run_op(4'h3, 4'h5, 4'b1110, 1'b0, 7'h30, 1'b0);  // 3&5=1
    run_op(4'h3, 4'h5, 4'b0011, 1'b0, 7'h70, 1'b0);  // 3|5=7
    run_op(4'h9, 4'h8, 4'b0001, 1'b1, 7'h30, 1'b0);  // 9-8 no borrow
    run_op(4'h5, 4'h3, 4'b0000, 1'b0, 7'h7F, 1'b0);  // 5+3=8 no carry
    run_op(4'h2, 4'hF, 4'b0001, 1'b0, 7'h79, 1'b0);  // 2-15 -> 3 with borrow
    run_op(4'hF, 4'h1, 4'b0000, 1'b1, 7'h7E, 1'b0);  // 15+1 -> 0 with carry

    press_hold(4'h6, 1'b0);
    release_btn();
    press_hold(4'h7, 1'b0);
    release_btn();
    sw  = 4'h2;
    btn = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    m_state = 0;
    m_a     = 4'h0;
    m_b     = 4'h0;
    m_op    = 2'b00;
    #1;
    chk("midrst_step", {28'h0, step}, 32'h1);
    chk("midrst_a", {28'h0, a}, 32'h0);
    chk("midrst_b", {28'h0, b}, 32'h0);
    chk("midrst_op", {30'h0, s1, s0}, 32'h0);
    chk("midrst_flag", {31'h0, flag_c}, 32'h0);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_step", {28'h0, step}, 32'h1);
    chk("post_rst_a", {28'h0, a}, 32'h0);

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
